// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2, usable at elaboration time.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Digit counter width; at least one bit so a single-digit adder still has a counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + carry_in, DIGIT bits per clock, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH divisible by DIGIT");
  end

  state_e          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] digit_sum;
  logic [WIDTH-1:0] sum_nx;

  assign in_ready  = (state == StIdle);
  assign out_valid = (state == StDone);

  assign chain[0] = c_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (chain[i]),
      .sum  (digit_sum[i]),
      .cout (chain[i+1])
    );
  end

  // New digit enters at the top of the sum; shift form also covers DIGIT == WIDTH.
  always_comb begin
    sum_nx = '0;
    sum_nx = (sum >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
  end

  // Handshake FSM plus operand/result datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            c_q   <= carry_in;
            cnt   <= '0;
            state <= StRun;
          end
        end
        StRun: begin
          a_q <= a_q >> DIGIT;
          b_q <= b_q >> DIGIT;
          c_q <= chain[DIGIT];
          sum <= sum_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LastCnt) begin
            carry_out <= chain[DIGIT];
            // chain[DIGIT-1] is the carry into the MSB on the last digit.
            overflow  <= chain[DIGIT-1] ^ chain[DIGIT];
            state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at DIGIT = 1, 4 and 8 with WIDTH = 8.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;

  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] sum_v     [3];
  logic       co_v      [3];
  logic       ov_v      [3];

  int   checks;
  int   errors;
  res_t q[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a), .b(b),
    .carry_in(cin), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum_v[0]),
    .carry_out(co_v[0]), .overflow(ov_v[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a), .b(b),
    .carry_in(cin), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum_v[1]),
    .carry_out(co_v[1]), .overflow(ov_v[1])
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a), .b(b),
    .carry_in(cin), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum_v[2]),
    .carry_out(co_v[2]), .overflow(ov_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 9-bit addition; signed overflow from operand/result sign bits.
  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    res_t r;
    t   = {1'b0, x} + {1'b0, y} + {8'd0, c};
    r.s = t[7:0];
    r.c = t[8];
    r.o = (x[7] == y[7]) && (t[7] != x[7]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on instance k, scramble inputs during RUN, wait for the result.
  task automatic send(input int k, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input int lat, input string tag, output res_t e);
    int n;
    a           = ta;
    b           = tb_;
    cin         = tc;
    in_valid[k] = 1'b1;
    q.push_back(model(ta, tb_, tc));
    tick();
    in_valid[k] = 1'b0;
    a           = 8'($urandom);
    b           = 8'($urandom);
    cin         = 1'($urandom);
    chk({tag, ".busy"}, 32'(in_ready[k]), 32'd0);
    n = 0;
    while (!out_valid[k] && n < 100) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    e = q.pop_front();
    chk({tag, ".sum"}, 32'(sum_v[k]), 32'(e.s));
    chk({tag, ".co"}, 32'(co_v[k]), 32'(e.c));
    chk({tag, ".ov"}, 32'(ov_v[k]), 32'(e.o));
  endtask

  initial begin
    res_t e;
    logic [7:0] hs;
    logic       hc;
    logic       ho;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end

    // Reset state.
    #3;
    chk("rst.in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst.out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst.sum", 32'(sum_v[0]), 32'd0);
    chk("rst.co", 32'(co_v[0]), 32'd0);
    chk("rst.ov", 32'(ov_v[0]), 32'd0);
    #9 rst = 1'b0;
    tick();

    // Basic DIGIT=1 cases.
    send(0, 8'h5A, 8'h3C, 1'b0, 8, "d1.5a3c", e);
    chk("d1.5a3c.sum_const", 32'(sum_v[0]), 32'h96);
    chk("d1.5a3c.ov_const", 32'(ov_v[0]), 32'd1);
    tick();
    chk("d1.after.in_ready", 32'(in_ready[0]), 32'd1);
    chk("d1.after.out_valid", 32'(out_valid[0]), 32'd0);
    send(0, 8'hFF, 8'h01, 1'b0, 8, "d1.ff01", e);
    chk("d1.ff01.co_const", 32'(co_v[0]), 32'd1);
    tick();
    send(0, 8'h7F, 8'h00, 1'b1, 8, "d1.7f00c", e);
    chk("d1.7f00c.sum_const", 32'(sum_v[0]), 32'h80);
    tick();

    // Backpressure: result held, new operands refused.
    out_ready[0] = 1'b0;
    send(0, 8'h12, 8'h34, 1'b1, 8, "d1.bp", e);
    hs = sum_v[0];
    hc = co_v[0];
    ho = ov_v[0];
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      a           = 8'($urandom);
      tick();
      chk("bp.out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp.in_ready", 32'(in_ready[0]), 32'd0);
      chk("bp.sum", 32'(sum_v[0]), 32'(e.s));
      chk("bp.co", 32'(co_v[0]), 32'(hc));
      chk("bp.ov", 32'(ov_v[0]), 32'(ho));
    end
    chk("bp.sum_first", 32'(hs), 32'h47);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    chk("bp.release.in_ready", 32'(in_ready[0]), 32'd1);
    chk("bp.release.out_valid", 32'(out_valid[0]), 32'd0);

    // Asynchronous reset three edges into RUN.
    a           = 8'hAA;
    b           = 8'h55;
    cin         = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid.in_ready", 32'(in_ready[0]), 32'd1);
    chk("mid.out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid.sum", 32'(sum_v[0]), 32'd0);
    #1 rst = 1'b0;
    send(0, 8'h01, 8'h01, 1'b0, 8, "mid.new", e);
    chk("mid.new.sum_const", 32'(sum_v[0]), 32'h02);
    tick();

    // DIGIT=4.
    send(1, 8'hF0, 8'h10, 1'b0, 2, "d4.f010", e);
    chk("d4.f010.sum_const", 32'(sum_v[1]), 32'h00);
    chk("d4.f010.co_const", 32'(co_v[1]), 32'd1);
    tick();
    send(1, 8'h7F, 8'h01, 1'b0, 2, "d4.7f01", e);
    tick();

    // DIGIT=8 random sweep.
    for (int i = 0; i < 1000; i++) begin
      send(2, 8'($urandom), 8'($urandom), 1'($urandom), 1, "d8.rand", e);
      tick();
    end

    chk("sb.empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
